multicycle_control: RTL and testbench



---
 rtl/multicycle_control.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the DLX multicycle processor
//
// Purpose: sequences each instruction through fetch/decode/execute/memory/
// writeback and drives every datapath control input.
// Ports:
//   Clock, Reset              rising-edge clock, asynchronous active-high reset
//   Opcode, Zero              IR opcode and ALU zero flag from the datapath
//   MemReady                  memory access completes this cycle
//   PCWriteCond .. RegWrite   1-bit datapath write enables and mux selects
//   PCSource .. MemToReg      2-bit datapath mux and ALU selects
//   Illegal                   one-cycle pulse on an undefined opcode
//   State                     current state (debug)
//   InstrCount                number of completed fetches (wraps)
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_BNE   = 6'h05,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_JAL   = 6'h03,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemToReg,
    output logic        Illegal,
    output logic [3:0]  State,
    output logic [31:0] InstrCount
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADDR  = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_RWB      = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_IEXEC    = 4'd10;
    localparam logic [3:0] S_IWB      = 4'd11;

    logic [3:0] state;
    logic [3:0] next_state;
    logic       is_imm;

    // Immediate-ALU opcodes occupy the eight codes starting at OP_ADDI.
    assign is_imm = (Opcode >= OP_ADDI) && (Opcode <= (OP_ADDI + 6'd7));
    assign State  = state;

    // State register and fetch counter
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_FETCH;
            InstrCount <= 32'd0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && MemReady)
                InstrCount <= InstrCount + 32'd1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Opcode == OP_LW || Opcode == OP_SW)       next_state = S_MEMADDR;
                else if (Opcode == OP_RTYPE)                  next_state = S_EXEC;
                else if (Opcode == OP_BEQ || Opcode == OP_BNE) next_state = S_BRANCH;
                else if (Opcode == OP_J || Opcode == OP_JAL)  next_state = S_JUMP;
                else if (is_imm)                              next_state = S_IEXEC;
                else                                          next_state = S_FETCH;
            end
            S_MEMADDR:  next_state = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: next_state = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXEC:     next_state = S_RWB;
            S_IEXEC:    next_state = S_IWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Output logic; Reset masks everything so nothing writes while held.
    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        RegDst      = 2'b00;
        MemToReg    = 2'b00;
        Illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                // JAL links PC+4, still held in ALUOutReg from FETCH.
                if (Opcode == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                end
                if (!(Opcode == OP_LW || Opcode == OP_SW || Opcode == OP_RTYPE ||
                      Opcode == OP_BEQ || Opcode == OP_BNE || Opcode == OP_J ||
                      Opcode == OP_JAL || is_imm))
                    Illegal = 1'b1;
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
                RegWrite = 1'b1;
                MemToReg = 2'b01;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                // The datapath does not gate PCWriteCond with Zero.
                PCWriteCond = ((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            default: Illegal = 1'b1;
        endcase
        if (Reset) begin
            PCWriteCond = 1'b0;
            PCWrite     = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            ALUSrcA     = 1'b0;
            RegWrite    = 1'b0;
            PCSource    = 2'b00;
            ALUOp       = 2'b00;
            ALUSrcB     = 2'b00;
            RegDst      = 2'b00;
            MemToReg    = 2'b00;
            Illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  Opcode = 6'h00;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b1;
    logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  PCSource, ALUOp, ALUSrcB, RegDst, MemToReg;
    logic        Illegal;
    logic [3:0]  State;
    logic [31:0] InstrCount;

    multicycle_control dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
        .MemToReg(MemToReg), .Illegal(Illegal), .State(State), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    // {Illegal, PCWriteCond, PCWrite, IorD, MemRead, MemWrite, IRWrite, ALUSrcA,
    //  RegWrite, PCSource, ALUOp, ALUSrcB, RegDst, MemToReg}
    logic [18:0] ctl;
    assign ctl = {Illegal, PCWriteCond, PCWrite, IorD, MemRead, MemWrite, IRWrite, ALUSrcA,
                  RegWrite, PCSource, ALUOp, ALUSrcB, RegDst, MemToReg};

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [18:0] cv(input logic ill, pcwc, pcw, iord, mr, mw, irw, srca, rw,
                                       input logic [1:0] pcsrc, aluop, srcb, rdst, m2r);
        return {ill, pcwc, pcw, iord, mr, mw, irw, srca, rw, pcsrc, aluop, srcb, rdst, m2r};
    endfunction

    logic [18:0] C_ZERO, C_FETCH, C_FETCH_WAIT, C_DECODE, C_DECODE_JAL, C_DECODE_ILL;
    logic [18:0] C_MEMADDR, C_MEMREAD, C_MEMWB, C_MEMWRITE, C_EXEC, C_RWB;
    logic [18:0] C_BRANCH_T, C_BRANCH_N, C_JUMP, C_IEXEC, C_IWB;

    logic [3:0]  eq_st[$];
    logic [18:0] eq_v[$];

    task automatic cyc_check(input string tag, input logic [3:0] st, input logic [18:0] v);
        check({tag, "_state"}, 32'(State), 32'(st));
        check({tag, "_ctl"}, 32'(ctl), 32'(v));
    endtask

    task automatic push(input logic [3:0] st, input logic [18:0] v);
        eq_st.push_back(st);
        eq_v.push_back(v);
    endtask

    // Runs one instruction from FETCH with MemReady=1, checking each cycle
    // against the pushed expectations and the total cycle count.
    task automatic run(input string tag, input logic [5:0] op, input logic z, input int n);
        int cyc;
        cyc = 0;
        Opcode = op;
        Zero = z;
        MemReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (i < eq_st.size()) cyc_check($sformatf("%s_c%0d", tag, i), eq_st[i], eq_v[i]);
            @(posedge Clock);
            #1;
            cyc++;
            if (State == 4'd0) break;
        end
        check({tag, "_cycles"}, 32'(cyc), 32'(n));
        eq_st.delete();
        eq_v.delete();
    endtask

    initial begin
        C_ZERO       = '0;
        C_FETCH      = cv(0,0,1,0,1,0,1,0,0, 0,0,1,0,0);
        C_FETCH_WAIT = cv(0,0,0,0,1,0,0,0,0, 0,0,1,0,0);
        C_DECODE     = cv(0,0,0,0,0,0,0,0,0, 0,0,3,0,0);
        C_DECODE_JAL = cv(0,0,0,0,0,0,0,0,1, 0,0,3,2,0);
        C_DECODE_ILL = cv(1,0,0,0,0,0,0,0,0, 0,0,3,0,0);
        C_MEMADDR    = cv(0,0,0,0,0,0,0,1,0, 0,0,2,0,0);
        C_MEMREAD    = cv(0,0,0,1,1,0,0,0,0, 0,0,0,0,0);
        C_MEMWB      = cv(0,0,0,1,1,0,0,0,1, 0,0,0,0,1);
        C_MEMWRITE   = cv(0,0,0,1,0,1,0,0,0, 0,0,0,0,0);
        C_EXEC       = cv(0,0,0,0,0,0,0,1,0, 0,2,0,0,0);
        C_RWB        = cv(0,0,0,0,0,0,0,0,1, 0,0,0,1,0);
        C_BRANCH_T   = cv(0,1,0,0,0,0,0,1,0, 1,1,0,0,0);
        C_BRANCH_N   = cv(0,0,0,0,0,0,0,1,0, 1,1,0,0,0);
        C_JUMP       = cv(0,0,1,0,0,0,0,0,0, 2,0,0,0,0);
        C_IEXEC      = cv(0,0,0,0,0,0,0,1,0, 0,3,2,0,0);
        C_IWB        = cv(0,0,0,0,0,0,0,0,1, 0,0,0,0,0);

        // Power-on reset
        repeat (2) @(posedge Clock);
        #1;
        cyc_check("por_hold", 4'd0, C_ZERO);
        check("por_count", InstrCount, 32'd0);
        #2 Reset = 1'b0;
        #1;
        cyc_check("por_fetch", 4'd0, C_FETCH);

        // Get into EXEC, then reset mid-instruction
        Opcode = 6'h00;
        @(posedge Clock); #1;
        cyc_check("pre_decode", 4'd1, C_DECODE);
        @(posedge Clock); #1;
        cyc_check("pre_exec", 4'd6, C_EXEC);
        check("pre_count", InstrCount, 32'd1);
        Reset = 1'b1;
        #1;
        cyc_check("rst_mid", 4'd0, C_ZERO);
        check("rst_mid_count", InstrCount, 32'd0);
        @(posedge Clock); #1;
        cyc_check("rst_held", 4'd0, C_ZERO);
        Reset = 1'b0;
        #1;
        cyc_check("rst_release", 4'd0, C_FETCH);
        check("rst_release_count", InstrCount, 32'd0);

        // ADD, LW, SW, ADDI, J
        push(0, C_FETCH); push(1, C_DECODE); push(6, C_EXEC); push(7, C_RWB);
        run("add", 6'h00, 1'b0, 4);
        push(0, C_FETCH); push(1, C_DECODE); push(2, C_MEMADDR); push(3, C_MEMREAD); push(4, C_MEMWB);
        run("lw", 6'h23, 1'b0, 5);
        push(0, C_FETCH); push(1, C_DECODE); push(2, C_MEMADDR); push(5, C_MEMWRITE);
        run("sw", 6'h2B, 1'b0, 4);
        push(0, C_FETCH); push(1, C_DECODE); push(10, C_IEXEC); push(11, C_IWB);
        run("addi", 6'h08, 1'b0, 4);
        push(0, C_FETCH); push(1, C_DECODE); push(9, C_JUMP);
        run("j", 6'h02, 1'b0, 3);
        check("count_after_5", InstrCount, 32'd5);

        // Branches: PCWriteCond gated by Zero, PCWrite never set
        push(0, C_FETCH); push(1, C_DECODE); push(8, C_BRANCH_T);
        run("beq_z1", 6'h04, 1'b1, 3);
        push(0, C_FETCH); push(1, C_DECODE); push(8, C_BRANCH_N);
        run("beq_z0", 6'h04, 1'b0, 3);
        push(0, C_FETCH); push(1, C_DECODE); push(8, C_BRANCH_T);
        run("bne_z0", 6'h05, 1'b0, 3);
        push(0, C_FETCH); push(1, C_DECODE); push(8, C_BRANCH_N);
        run("bne_z1", 6'h05, 1'b1, 3);

        // JAL links in DECODE
        push(0, C_FETCH); push(1, C_DECODE_JAL); push(9, C_JUMP);
        run("jal", 6'h03, 1'b0, 3);

        // Illegal opcode and immediate-range boundaries
        push(0, C_FETCH); push(1, C_DECODE_ILL);
        run("ill_3f", 6'h3F, 1'b0, 2);
        #1;
        check("ill_one_cycle", 32'(Illegal), 32'd0);
        push(0, C_FETCH); push(1, C_DECODE); push(10, C_IEXEC); push(11, C_IWB);
        run("imm_0f", 6'h0F, 1'b0, 4);
        push(0, C_FETCH); push(1, C_DECODE_ILL);
        run("ill_10", 6'h10, 1'b0, 2);

        // LW with three not-ready cycles in MEMREAD
        Opcode = 6'h23;
        MemReady = 1'b1;
        #1;
        cyc_check("lww_fetch", 4'd0, C_FETCH);
        @(posedge Clock); #1;
        cyc_check("lww_decode", 4'd1, C_DECODE);
        @(posedge Clock); #1;
        cyc_check("lww_memaddr", 4'd2, C_MEMADDR);
        @(posedge Clock); #1;
        MemReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            cyc_check($sformatf("lww_wait%0d", k), 4'd3, C_MEMREAD);
            @(posedge Clock); #1;
        end
        MemReady = 1'b1;
        #1;
        cyc_check("lww_ready", 4'd3, C_MEMREAD);
        @(posedge Clock); #1;
        cyc_check("lww_memwb", 4'd4, C_MEMWB);
        @(posedge Clock); #1;
        check("lww_back", 32'(State), 32'd0);

        // FETCH stalls without counting
        MemReady = 1'b0;
        #1;
        cyc_check("fw_0", 4'd0, C_FETCH_WAIT);
        @(posedge Clock); #1;
        cyc_check("fw_1", 4'd0, C_FETCH_WAIT);
        check("fw_count", InstrCount, 32'd14);
        MemReady = 1'b1;
        Opcode = 6'h02;
        #1;
        cyc_check("fw_ready", 4'd0, C_FETCH);
        @(posedge Clock); #1;
        check("fw_decode", 32'(State), 32'd1);
        check("final_count", InstrCount, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
